// File: rtl/regfile_sb.sv
// Scoreboarded register file: two combinational read ports with write bypass,
// one writeback port, one reservation port, and a post-reset zeroing sweep.
module regfile_sb #(
  parameter  int WIDTH    = 24,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             core_clock_i,
  input  logic             core_reset_i,
  output logic             init_done_o,
  input  logic [AW-1:0]    rs1_i,
  output logic [WIDTH-1:0] rs1_data_o,
  output logic             rs1_busy_o,
  input  logic [AW-1:0]    rs2_i,
  output logic [WIDTH-1:0] rs2_data_o,
  output logic             rs2_busy_o,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rsv_en_i,
  input  logic [AW-1:0]    rsv_i
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);

  state_t             state_r;
  state_t             state_s;
  logic [AW-1:0]      cnt_r;
  logic [AW-1:0]      cnt_s;
  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0]   pend_r;
  logic [DEPTH-1:0]   pend_s;
  logic               mem_we_s;
  logic [AW-1:0]      mem_addr_s;
  logic [WIDTH-1:0]   mem_wdata_s;
  logic               ready_s;
  logic               wr_act_s;
  logic               rsv_act_s;
  logic [AW-1:0]      rd_addr_s [2];
  logic [WIDTH-1:0]   rd_data_s [2];
  logic               rd_busy_s [2];

  // Register 0 is only special when the hardwired-zero option is enabled.
  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == {AW{1'b0}});
  endfunction

  assign ready_s   = (state_r == ST_READY);
  assign wr_act_s  = ready_s && wr_en_i && !is_zero_reg(wr_i);
  assign rsv_act_s = ready_s && rsv_en_i && !is_zero_reg(rsv_i);

  // FSM state and sweep counter.
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      state_r <= ST_INIT;
      cnt_r   <= {AW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: sweep every entry once, then stay ready.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_s = cnt_r + AW'(1);
        if (cnt_r == LAST_ENTRY) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_READY: begin
        state_s = ST_READY;
        cnt_s   = cnt_r;
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = {AW{1'b0}};
      end
    endcase
  end

  // Storage write mux: the sweep owns the single write port until ready.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = {AW{1'b0}};
    mem_wdata_s = {WIDTH{1'b0}};
    case (state_r)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = cnt_r;
        mem_wdata_s = {WIDTH{1'b0}};
      end
      ST_READY: begin
        mem_we_s    = wr_act_s;
        mem_addr_s  = wr_i;
        mem_wdata_s = wr_data_i;
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge core_clock_i) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Pending flags next value: a reservation beats a same-cycle writeback.
  always_comb begin
    pend_s = pend_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_act_s && (rsv_i == AW'(i))) begin
        pend_s[i] = 1'b1;
      end else if (wr_act_s && (wr_i == AW'(i))) begin
        pend_s[i] = 1'b0;
      end else begin
        pend_s[i] = pend_r[i];
      end
    end
  end

  // Pending flags.
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_s;
    end
  end

  assign rd_addr_s[0] = rs1_i;
  assign rd_addr_s[1] = rs2_i;

  // Read ports: masked until ready; a same-cycle writeback is forwarded,
  // a same-cycle reservation is not.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = {WIDTH{1'b0}};
      rd_busy_s[p] = 1'b0;
      if (!ready_s) begin
        rd_data_s[p] = {WIDTH{1'b0}};
        rd_busy_s[p] = 1'b0;
      end else if (is_zero_reg(rd_addr_s[p])) begin
        rd_data_s[p] = {WIDTH{1'b0}};
        rd_busy_s[p] = 1'b0;
      end else if (wr_act_s && (wr_i == rd_addr_s[p])) begin
        rd_data_s[p] = wr_data_i;
        rd_busy_s[p] = 1'b0;
      end else begin
        rd_data_s[p] = mem_r[rd_addr_s[p]];
        rd_busy_s[p] = pend_r[rd_addr_s[p]];
      end
    end
  end

  assign init_done_o = ready_s;
  assign rs1_data_o  = rd_data_s[0];
  assign rs1_busy_o  = rd_busy_s[0];
  assign rs2_data_o  = rd_data_s[1];
  assign rs2_busy_o  = rd_busy_s[1];

endmodule
